// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, fetch FSM states, opcodes and field slices.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    // Major opcodes decoded by UC
    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_OP_IMM = 7'd19;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JAL    = 7'd111;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

endpackage

// File: rtl/next_pc_adder.sv
// Combinational next-PC select: pc+4 or pc+imm, with the low target bits cleared
// and a flag raised when the raw branch target is not word aligned.
module next_pc_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_pc_src,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seq;

    assign w_target     = i_pc + i_imm;
    assign w_seq        = i_pc + XLEN'(4);
    assign o_next_pc    = i_pc_src ? {w_target[XLEN-1:2], 2'b00} : w_seq;
    assign o_misaligned = i_pc_src & (w_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over req/ack, presents op/f3/f7 to UC.
// Optional MISALIGN_TRAP_EN adds a sticky TRAP state and the trap port.
module fetch_unit #(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instrValid,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      f3,
    output logic [6:0]      f7,
    output logic [XLEN-1:0] pc,
`ifdef MISALIGN_TRAP_EN
    output logic            trap,
`endif
    input  logic            execDone,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] immExt,
    output logic [31:0]     instret,
    output logic [1:0]      o_dbg_state
);

    import riscv_pkg::*;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [31:0]     r_instret;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;

    next_pc_adder #(.XLEN(XLEN)) u_next_pc (
        .i_pc        (r_pc),
        .i_imm       (immExt),
        .i_pc_src    (pcSrc),
        .o_next_pc   (w_next_pc),
        .o_misaligned(w_misaligned)
    );

    // Handshake: imem_req holds in REQ until a rising edge samples imem_ack=1;
    // instrValid holds in ISSUE until a rising edge samples execDone=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_instret <= '0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_REQ;
                ST_REQ: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (execDone) begin
`ifdef MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state <= ST_TRAP;
                        end else begin
                            r_pc      <= w_next_pc;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= ST_REQ;
                        end
`else
                        r_pc      <= w_next_pc;
                        r_instret <= r_instret + 32'd1;
                        r_state   <= ST_REQ;
`endif
                    end
                end
`ifdef MISALIGN_TRAP_EN
                ST_TRAP: r_state <= ST_TRAP;
`endif
                default: r_state <= ST_BOOT;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (r_state == ST_TRAP);
`else
    // Without the trap the low target bits are simply dropped by the adder.
    logic w_unused;
    assign w_unused = w_misaligned;
`endif

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = imem_req ? r_pc : '0;
    assign instrValid  = (r_state == ST_ISSUE);
    assign instr       = r_instr;
    assign op          = r_instr[OP_MSB:OP_LSB];
    assign f3          = r_instr[F3_MSB:F3_LSB];
    assign f7          = r_instr[F7_MSB:F7_LSB];
    assign pc          = r_pc;
    assign instret     = r_instret;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours MISALIGN_TRAP_EN when defined.
module tb_fetch_unit;

    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instrValid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic        execDone;
    logic        pcSrc;
    logic [31:0] immExt;
    logic [31:0] instret;
    logic [1:0]  dbg_state;
`ifdef MISALIGN_TRAP_EN
    logic        trap;
`endif

    int n_checks;
    int n_errors;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instrValid (instrValid),
        .instr      (instr),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .pc         (pc),
`ifdef MISALIGN_TRAP_EN
        .trap       (trap),
`endif
        .execDone   (execDone),
        .pcSrc      (pcSrc),
        .immExt     (immExt),
        .instret    (instret),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch one word: ack in REQ, land in ISSUE.
    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic execute(input logic src, input logic [31:0] imm);
        execDone = 1'b1;
        pcSrc    = src;
        immExt   = imm;
        tick();
        execDone = 1'b0;
        pcSrc    = 1'b0;
        immExt   = '0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        execDone   = 1'b0;
        pcSrc      = 1'b0;
        immExt     = '0;

        // Reset for two cycles, then observe the BOOT cycle
        tick();
        tick();
        rst = 1'b0;
        check("boot_state", 32'(dbg_state), 32'(ST_BOOT));
        check("boot_req", 32'(imem_req), 32'd0);
        check("boot_addr", imem_addr, 32'd0);
        check("boot_valid", 32'(instrValid), 32'd0);
        check("boot_instr", instr, 32'd0);
        check("boot_pc", pc, 32'd0);
        check("boot_instret", instret, 32'd0);
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'd0);

        // LOAD with three wait cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_valid", 32'(instrValid), 32'd0);
        end
        fetch(32'h0000_2003);
        check("load_valid", 32'(instrValid), 32'd1);
        check("load_req", 32'(imem_req), 32'd0);
        check("load_addr", imem_addr, 32'd0);
        check("load_op", 32'(op), 32'd3);
        check("load_f3", 32'(f3), 32'd2);
        check("load_f7", 32'(f7), 32'd0);
        execute(1'b0, 32'd0);
        check("load_next_req", 32'(imem_req), 32'd1);
        check("load_next_addr", imem_addr, 32'd4);
        check("load_instret", instret, 32'd1);
        check("load_next_valid", 32'(instrValid), 32'd0);

        // SUB, held in ISSUE while a stray ack arrives
        fetch(32'h4000_0033);
        check("sub_op", 32'(op), 32'd51);
        check("sub_f3", 32'(f3), 32'd0);
        check("sub_f7", 32'(f7), 32'h20);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sub_hold_instr", instr, 32'h4000_0033);
            check("sub_hold_valid", 32'(instrValid), 32'd1);
        end
        imem_ack = 1'b0;
        check("sub_hold_instret", instret, 32'd1);
        execute(1'b0, 32'd0);
        check("sub_next_addr", imem_addr, 32'd8);
        check("sub_instret", instret, 32'd2);

        // Taken branch from pc=8 by -8
        fetch(32'h0000_0063);
        check("br_op", 32'(op), 32'd99);
        check("br_pc", pc, 32'd8);
        execute(1'b1, 32'hFFFF_FFF8);
        check("br_next_addr", imem_addr, 32'd0);
        check("br_instret", instret, 32'd3);

        // Jump to the top word, then wrap back to 0 with pc+4
        fetch(32'h0000_006F);
        execute(1'b1, 32'hFFFF_FFFC);
        check("jal_next_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        execute(1'b0, 32'd0);
        check("wrap_next_addr", imem_addr, 32'd0);
        check("wrap_instret", instret, 32'd5);

        // Misaligned branch target 0+6
        fetch(32'h0000_0063);
        check("mis_pc", pc, 32'd0);
        execute(1'b1, 32'd6);
`ifdef MISALIGN_TRAP_EN
        check("mis_trap", 32'(trap), 32'd1);
        check("mis_state", 32'(dbg_state), 32'(ST_TRAP));
        check("mis_pc_kept", pc, 32'd0);
        check("mis_instret", instret, 32'd5);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trap_req", 32'(imem_req), 32'd0);
            check("trap_valid", 32'(instrValid), 32'd0);
            check("trap_sticky", 32'(trap), 32'd1);
        end
        imem_ack = 1'b0;
`else
        check("mis_next_req", 32'(imem_req), 32'd1);
        check("mis_next_addr", imem_addr, 32'd4);
        check("mis_instret", instret, 32'd6);
`endif

        // Reset with a coincident and a late ack
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        check("rst_state", 32'(dbg_state), 32'(ST_BOOT));
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_pc", pc, 32'd0);
        tick();
        check("late_ack_state", 32'(dbg_state), 32'(ST_REQ));
        check("late_ack_valid", 32'(instrValid), 32'd0);
        check("late_ack_instr", instr, 32'd0);
        check("restart_addr", imem_addr, 32'd0);
        fetch(32'h0010_0093);
        check("restart_valid", 32'(instrValid), 32'd1);
        check("restart_instr", instr, 32'h0010_0093);
        check("restart_pc", pc, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
